// File: rtl/alu_operand_stage_if.sv
// Operand request / operand delivery bundle for one ALU operand stage.
interface alu_operand_stage_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned IMM_W   = 16
);
   logic [NUM_SRC*WIDTH-1:0] src_data;
   logic [SEL_W-1:0]         sel;
   logic [IMM_W-1:0]         imm;
   logic [1:0]               imm_mode;
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         out_data;
   logic                     out_err;
   logic                     out_valid;
   logic                     out_ready;

   // Requester side: issues operand requests and consumes results.
   modport master (
      output src_data, sel, imm, imm_mode, in_valid, out_ready,
      input  in_ready, out_data, out_err, out_valid
   );

   // Stage side.
   modport slave (
      input  src_data, sel, imm, imm_mode, in_valid, out_ready,
      output in_ready, out_data, out_err, out_valid
   );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered N-source / immediate operand select with a 2-entry (output + skid) buffer.
module alu_operand_stage #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned SEL_W   = 2,
   parameter int unsigned IMM_W   = 16
) (
   input logic                clk,
   input logic                rst_n,
   input logic                flush_i,
   alu_operand_stage_if.slave bus
);

   logic [WIDTH-1:0] sel_data;
   logic             sel_err;

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_err_q, out_err_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] skid_data_q, skid_data_d;
   logic             skid_err_q, skid_err_d;
   logic             skid_valid_q, skid_valid_d;

   logic accept;
   logic drain;

   // Operand selection ahead of the registers; out-of-range source reads as zero with err.
   always_comb begin
      sel_data = '0;
      sel_err  = 1'b0;
      case (bus.imm_mode)
         2'b00: begin
            sel_err = 1'b1;
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
               if (32'(bus.sel) == k) begin
                  sel_data = bus.src_data[k*WIDTH +: WIDTH];
                  sel_err  = 1'b0;
               end
            end
         end
         2'b01:   sel_data = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
         2'b10:   sel_data = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
         default: sel_data = {bus.imm, {(WIDTH-IMM_W){1'b0}}};
      endcase
   end

   // in_ready is the registered "skid empty" flag, so out_ready never reaches it combinationally.
   assign accept = bus.in_valid & ~skid_valid_q;
   assign drain  = out_valid_q & bus.out_ready;

   // Next-state for output register and skid entry; flush overrides every handshake.
   always_comb begin
      out_data_d   = out_data_q;
      out_err_d    = out_err_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_err_d   = skid_err_q;
      skid_valid_d = skid_valid_q;
      if (flush_i) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || drain) begin
         // Output slot is free this edge: skid (older) wins, else take the new request.
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_err_d    = skid_err_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_data_d  = sel_data;
            out_err_d   = sel_err;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_data_d  = sel_data;
         skid_err_d   = sel_err;
         skid_valid_d = 1'b1;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q   <= '0;
         out_err_q    <= 1'b0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_err_q   <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_err_q    <= out_err_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_err_q   <= skid_err_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign bus.in_ready  = ~skid_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;
   assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: driver pushes expectations, monitor pops on output handshakes.
module tb_alu_operand_stage;
   localparam int unsigned WIDTH   = 32;
   localparam int unsigned NUM_SRC = 3;
   localparam int unsigned SEL_W   = 2;
   localparam int unsigned IMM_W   = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   alu_operand_stage_if #(
      .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .IMM_W(IMM_W)
   ) bus ();

   alu_operand_stage #(
      .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .IMM_W(IMM_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush_i(flush),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;
   logic stream_on = 1'b0;
   int   stream_n  = 0;
   int   first_cyc = -1;
   int   last_cyc  = -1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [WIDTH-1:0] act,
                        input logic [WIDTH-1:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every output handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
         if (stream_on) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            stream_n++;
         end
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got 0x%0h expected none", bus.out_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_err", {31'b0, bus.out_err}, {31'b0, e.err});
         end
      end
   end

   // Drive one request (called at posedge+1), push expectation when it will be accepted.
   task automatic req(input logic [1:0] mode, input logic [SEL_W-1:0] s,
                      input logic [IMM_W-1:0] im, input logic [WIDTH-1:0] ed, input logic ee);
      exp_t e;
      bus.imm_mode = mode;
      bus.sel      = s;
      bus.imm      = im;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            e.data = ed;
            e.err  = ee;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: got in_ready=0 expected in_ready=1");
   endtask

   task automatic drain_wait();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      bus.src_data  = {32'h0000_00AB, 32'h0000_0011, 32'h0000_0005};
      bus.sel       = '0;
      bus.imm       = '0;
      bus.imm_mode  = 2'b00;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_err", {31'b0, bus.out_err}, 32'd0);
      check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // 1: source select with one-cycle latency
      bus.out_ready = 1'b1;
      req(2'b00, 2'd2, 16'h0, 32'h0000_00AB, 1'b0);
      @(negedge clk);
      check("latency_valid", {31'b0, bus.out_valid}, 32'd1);
      @(posedge clk);
      #1;

      // 2: immediate modes (sel ignored even though out of range)
      req(2'b01, 2'd3, 16'h8001, 32'hFFFF_8001, 1'b0);
      req(2'b10, 2'd3, 16'h8001, 32'h0000_8001, 1'b0);
      req(2'b11, 2'd3, 16'h8001, 32'h8001_0000, 1'b0);

      // 3: out-of-range select, then recovery
      req(2'b00, 2'd3, 16'h0, 32'h0, 1'b1);
      req(2'b00, 2'd0, 16'h0, 32'h0000_0005, 1'b0);
      drain_wait();

      // 4: backpressure through the skid entry
      bus.out_ready = 1'b0;
      fork
         begin
            req(2'b10, 2'd0, 16'h1, 32'h1, 1'b0);
            req(2'b10, 2'd0, 16'h2, 32'h2, 1'b0);
            req(2'b10, 2'd0, 16'h3, 32'h3, 1'b0);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            check("bp_out_data", bus.out_data, 32'h1);
            repeat (3) @(negedge clk);
            check("bp_hold_data", bus.out_data, 32'h1);
            check("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            @(posedge clk);
            #1 bus.out_ready = 1'b1;
         end
      join
      drain_wait();

      // 5: 100 back-to-back operands
      stream_on = 1'b1;
      begin
         int c0;
         c0 = cyc;
         for (int i = 0; i < 100; i++)
            req(2'b10, 2'd0, 16'(i + 16'h100), 32'(i + 16'h100), 1'b0);
         check("stream_in_cycles", 32'(cyc - c0), 32'd100);
      end
      drain_wait();
      stream_on = 1'b0;
      check("stream_count", 32'(stream_n), 32'd100);
      check("stream_span", 32'(last_cyc - first_cyc), 32'd99);

      // 6a: flush with output and skid full plus a same-cycle request
      bus.out_ready = 1'b0;
      req(2'b10, 2'd0, 16'hA1, 32'hA1, 1'b0);
      req(2'b10, 2'd0, 16'hA2, 32'hA2, 1'b0);
      bus.imm      = 16'hA3;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("flush_no_stale", {31'b0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      req(2'b10, 2'd0, 16'hB1, 32'hB1, 1'b0);
      drain_wait();

      // 6b: asynchronous reset mid-stall
      bus.out_ready = 1'b0;
      req(2'b10, 2'd0, 16'hC1, 32'hC1, 1'b0);
      @(negedge clk);
      check("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      check("arst_out_data", bus.out_data, 32'd0);
      check("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      req(2'b01, 2'd0, 16'h7FFF, 32'h0000_7FFF, 1'b0);
      drain_wait();

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
Parametrised, registered operand-select stage feeding one ALU input port. It replaces the fixed 32-bit two-way register/immediate select with an N-source select and an immediate-extension mode. A valid/ready handshake with a 2-entry skid buffer lets the ALU stall without losing operands. One instance is used per ALU operand (A and B).

Parameters:
WIDTH, 32, data width of every source and of the output
NUM_SRC, 4, number of selectable register/forwarding sources (2..16)
SEL_W, 2, width of sel; must be at least ceil(log2(NUM_SRC))
IMM_W, 16, width of raw immediate field; must be less than WIDTH

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffered operands
src_data  input  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH]
sel  input  SEL_W  source index, used when imm_mode=00
imm  input  IMM_W  raw immediate
imm_mode  input  2  00 source, 01 sign-extend imm, 10 zero-extend imm, 11 imm placed in the upper bits (upper-immediate load)
in_valid  input  1  operand request valid
in_ready  output  1  stage can accept a request
out_data  output  WIDTH  selected operand
out_err  output  1  request used sel >= NUM_SRC with imm_mode=00
out_valid  output  1  out_data/out_err valid
out_ready  input  1  ALU consumes operand

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_err=0, skid entry empty, in_ready=1. Reset asserted mid-transfer discards all held operands.
- Selection (combinational, ahead of the registers):
  - mode 00: src_data slice sel.
  - mode 01: {(WIDTH-IMM_W){imm[IMM_W-1]}, imm}.
  - mode 10: zero-extended imm.
  - mode 11: imm in the top IMM_W bits, zeros below.
- Out-of-range select: mode 00 with sel >= NUM_SRC gives value 0 and err=1. err is 0 in all other cases. sel is ignored when the mode is not 00.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. Latency is 1 cycle: an accepted request appears on out_* at the next edge when the output register is empty or being drained.
- Storage: output register plus one skid entry.
  - in_ready = skid entry empty. It is registered, so it has no combinational path from out_ready.
  - Accept while the output is empty or draining: the output register loads the new operand.
  - Accept while the output is full and not draining: the operand goes to the skid entry, and in_ready drops on the next cycle.
  - Output drains while the skid is full: the skid moves to the output register, the skid empties, and in_ready rises.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_err hold stable.
- Ordering: operands leave strictly in acceptance order.
- Simultaneous accept and drain with an empty skid: the output register takes the new operand and out_valid stays 1. No bubble is allowed.
- flush:
  - Clears out_valid and skid, sets in_ready=1 next cycle.
  - A request presented in the same cycle as flush is dropped.
  - out_data may keep a stale value; only out_valid is meaningful.
  - flush has priority over every handshake event.
- Throughput: one operand per cycle while out_ready is held at 1.

Test Plan:
1. Reset then mode 00, sel=2, src2=0x0000_00AB, in_valid=1, out_ready=1 -> out_valid=1 with out_data=0x0000_00AB, out_err=0 exactly one cycle later. Output values after reset: out_valid=0, out_data=0, out_err=0, in_ready=1.
2. Immediate modes with imm=0x8001: mode 01 -> 0xFFFF_8001; mode 10 -> 0x0000_8001; mode 11 -> 0x8001_0000.
3. Error path with NUM_SRC=3, sel=3, mode 00 -> out_data=0, out_err=1. Next request with sel=0, src0=0x5 -> out_err=0, out_data=0x5.
4. Backpressure: hold out_ready=0 and present values 0x1, 0x2, 0x3 on consecutive cycles.
   - 0x1 goes to the output register and 0x2 to the skid.
   - in_ready=0 and 0x3 is held by the source.
   - out_data stays 0x1.
   - Release out_ready: 0x1, 0x2, 0x3 emerge in order with no loss or duplication.
5. Streaming 100 back-to-back requests with out_ready=1 -> 100 outputs on consecutive cycles, order preserved, in_ready constantly 1.
6. flush with the output and skid both full, plus a new request in the same cycle -> next cycle out_valid=0, in_ready=1, and no operand from before the flush ever appears. Separately, assert rst_n low asynchronously mid-stall -> out_valid=0 immediately, without waiting for a clock edge.
